inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Instruction fetch stage directly upstream of the single-cycle CPU datapath. The block owns the fetch PC and issues word-aligned requests to instruction memory over a req/ack handshake. Returned words are buffered with their PC in a small FIFO and presented to decode over a valid/ready interface. Branch and jump redirects flush the queue and squash any in-flight response.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: fetch PC after reset.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  fetch enable; when low, no new request is issued.
- redirect_i  in  1  branch/jump taken this cycle.
- redirect_pc_i  in  32  redirect target; bits [1:0] are ignored and treated as 00.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address; always word-aligned.
- imem_ack_i  in  1  memory returns data this cycle.
- imem_data_i  in  32  instruction word, valid while imem_ack_i is high.
- inst_valid_o  out  1  head entry valid.
- inst_o  out  32  head instruction.
- inst_pc_o  out  32  PC of the head instruction.
- inst_ready_i  in  1  decode consumes the head entry.
- count_o  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Registered state: fetch_pc, request FSM, FIFO of {pc, inst}.
- FSM states:
  - IDLE: no request outstanding. If start_i is high and count is less than DEPTH, go to REQ with imem_addr_o = fetch_pc.
  - REQ: imem_req_o is high and imem_addr_o is stable until imem_ack_i is sampled high.
    - On ack, push {imem_addr_o, imem_data_i} and set fetch_pc to fetch_pc + 4.
    - After the ack, if start_i is high and the post-update count is less than DEPTH, stay in REQ with the new address (back-to-back). Otherwise go to IDLE.
  - DROP: a redirect arrived while a request was unacked. imem_req_o stays high on the old address, because a request is never withdrawn. On ack, the data is discarded and the FSM applies the IDLE issue rule to the new fetch_pc.
- Only one request is outstanding at a time. Issue requires count < DEPTH, so an ack never meets a full FIFO.
- Pop: inst_valid_o && inst_ready_i removes the head entry. A push and a pop in the same cycle leave count unchanged.
- Redirect has the highest priority:
  - The FIFO is cleared, so count is 0 next cycle.
  - fetch_pc takes {redirect_pc_i[31:2], 2'b00}.
  - A pop or an ack in the same cycle is ignored; the acked data is dropped and the FSM goes to IDLE-rule issue.
  - If a request is outstanding and not acked that cycle, the FSM goes to DROP.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- inst_o and inst_pc_o reflect the head entry combinationally from storage. They read 0 when the FIFO is empty.
- start_i falling does not cancel an outstanding request; the FIFO continues to drain.

## Timing
- Reset values: imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_pc_o=0, count_o=0, FSM=IDLE, fetch_pc=RESET_PC.
- start_i high in cycle t (IDLE, space available): imem_req_o high in cycle t+1.
- Ack in cycle t: the entry is visible on inst_valid_o in cycle t+1. A back-to-back request presents addr+4 in cycle t+1.
- Redirect in cycle t with nothing outstanding: inst_valid_o low and imem_req_o high on the target in cycle t+1.
- Reset asserted mid-request: all state returns to reset values immediately. Any later ack is ignored while in IDLE.

## Configuration
- IFQ_PERF_EN defined: adds ports fetch_cnt_o (out 32, incremented per accepted ack) and drop_cnt_o (out 32, incremented per discarded ack). Both reset to 0 and wrap.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Package ifq_pkg holds:
  - the FSM state enum {IDLE, REQ, DROP};
  - the instruction-width and PC-step constants;
  - the default RESET_PC.
- One sub-module, ifq_fifo: storage, read/write pointers, count, and a synchronous clear. The FSM and fetch_pc stay in the top level.

## Test plan
- Reset release, start_i=1, ack every cycle, ready=1: addresses 0,4,8,…; each instruction appears at inst_pc_o one cycle after its ack.
- ready=0, DEPTH=4, immediate acks: exactly 4 entries, count_o=4, imem_req_o low; one pop leads to a new request on address 16.
- Redirect to 32'h0000_0102 while a request is unacked, ack 3 cycles later: that data is dropped, the FIFO is empty, and the next request is on 32'h0000_0100.
- Redirect and ack in the same cycle, along with a pop: count_o=0 next cycle and the acked word never appears on inst_o.
- Redirect to 32'hFFFF_FFFC with continuous acks: entries at FFFF_FFFC then 0000_0000.
- rst_i pulsed low mid-REQ: outputs return to reset values asynchronously; with IFQ_PERF_EN defined, the counters read 0.

Source files
------------

// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types and constants for the instruction fetch queue.
// Holds the request FSM state encoding, datapath widths, the PC step
// and the default reset PC, plus a PC alignment helper.
package ifq_pkg;

  // Request FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } ifq_state_e;

  localparam int          INST_W           = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Force a PC onto a word boundary; the low two bits are discarded.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: DEPTH-entry {pc, inst} FIFO with occupancy count and a
// synchronous clear that takes priority over push and pop.
// The head entry is presented combinationally and reads 0 when empty.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [INST_W-1:0]      pc_i,
  input  logic [INST_W-1:0]      inst_i,
  output logic                   valid_o,
  output logic [INST_W-1:0]      pc_o,
  output logic [INST_W-1:0]      inst_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [INST_W-1:0] pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;

  // Pointer and occupancy update; clear wins over push/pop
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else if (clr_i) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents past the read pointer are never observed
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) begin
      pc_mem_q[wr_ptr_q]   <= pc_i;
      inst_mem_q[wr_ptr_q] <= inst_i;
    end
  end

  // Head entry presentation, zero when empty
  always_comb begin
    if (count_q != {CW{1'b0}}) begin
      valid_o = 1'b1;
      pc_o    = pc_mem_q[rd_ptr_q];
      inst_o  = inst_mem_q[rd_ptr_q];
    end else begin
      valid_o = 1'b0;
      pc_o    = 32'h0000_0000;
      inst_o  = 32'h0000_0000;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: owns the fetch PC, issues one word-aligned imem
// request at a time, and buffers returned words with their PC for decode.
// A redirect flushes the FIFO and squashes an in-flight response (DROP).
// Optional build macro IFQ_PERF_EN adds fetch_cnt_o / drop_cnt_o counters.
module inst_fetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   redirect_i,
  input  logic [INST_W-1:0]      redirect_pc_i,
  output logic                   imem_req_o,
  output logic [INST_W-1:0]      imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [INST_W-1:0]      imem_data_i,
  output logic                   inst_valid_o,
  output logic [INST_W-1:0]      inst_o,
  output logic [INST_W-1:0]      inst_pc_o,
  input  logic                   inst_ready_i,
  output logic [$clog2(DEPTH):0] count_o
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0]            fetch_cnt_o,
  output logic [31:0]            drop_cnt_o
`endif
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  ifq_state_e        state_q, state_d;
  logic [INST_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [INST_W-1:0] addr_q, addr_d;
  logic              push_s, pop_s, clr_s, valid_s;
  logic [CW-1:0]     count_s, pop_w_s, cnt_push_s, cnt_pop_s;

  // A pop is ignored in a redirect cycle because the FIFO is being cleared
  assign pop_s      = valid_s && inst_ready_i && !redirect_i;
  assign pop_w_s    = {{(CW-1){1'b0}}, pop_s};
  assign cnt_push_s = count_s + ONE_C - pop_w_s;
  assign cnt_pop_s  = count_s - pop_w_s;

  // Next-state, fetch PC and request address selection
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push_s     = 1'b0;
    clr_s      = 1'b0;
    if (redirect_i) begin
      clr_s      = 1'b1;
      fetch_pc_d = align_pc(redirect_pc_i);
      if ((state_q != IDLE) && !imem_ack_i) begin
        // Request still in flight: keep it on the bus, discard its data later
        state_d = DROP;
      end else if (start_i) begin
        state_d = REQ;
        addr_d  = align_pc(redirect_pc_i);
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && (count_s < DEPTH_C)) begin
            state_d = REQ;
            addr_d  = fetch_pc_q;
          end else begin
            state_d = IDLE;
          end
        end
        REQ: begin
          if (imem_ack_i) begin
            push_s     = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STEP;
            if (start_i && (cnt_push_s < DEPTH_C)) begin
              state_d = REQ;
              addr_d  = fetch_pc_q + PC_STEP;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = REQ;
          end
        end
        DROP: begin
          if (imem_ack_i) begin
            if (start_i && (cnt_pop_s < DEPTH_C)) begin
              state_d = REQ;
              addr_d  = fetch_pc_q;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = DROP;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // FSM, fetch PC and request address registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_s),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .pc_i    (addr_q),
    .inst_i  (imem_data_i),
    .valid_o (valid_s),
    .pc_o    (inst_pc_o),
    .inst_o  (inst_o),
    .count_o (count_s)
  );

  assign imem_req_o   = (state_q != IDLE);
  assign imem_addr_o  = addr_q;
  assign inst_valid_o = valid_s;
  assign count_o      = count_s;

`ifdef IFQ_PERF_EN
  logic        drop_ack_s;
  logic [31:0] fetch_cnt_q, drop_cnt_q;

  // Acked data is discarded in DROP, or in REQ when a redirect coincides
  assign drop_ack_s = imem_ack_i && ((state_q == DROP) || (redirect_i && (state_q == REQ)));

  // Wrapping accepted/discarded ack counters
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_q <= 32'd0;
      drop_cnt_q  <= 32'd0;
    end else begin
      if (push_s) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (drop_ack_s) begin
        drop_cnt_q <= drop_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based reference model of the fetch
// queue (outstanding-request flag, squash flag, entry queue).
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
  logic [2:0]  count_o;
`ifdef IFQ_PERF_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] drop_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  inst_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i),
    .count_o       (count_o)
`ifdef IFQ_PERF_EN
    ,
    .fetch_cnt_o   (fetch_cnt_o),
    .drop_cnt_o    (drop_cnt_o)
`endif
  );

  // Reference model state
  ent_t        mq[$];
  bit          m_busy;
  bit          m_squash;
  logic [31:0] m_addr;
  logic [31:0] m_pc;
  logic [31:0] m_fetch;
  logic [31:0] m_drop;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy   = 1'b0;
    m_squash = 1'b0;
    m_addr   = RPC;
    m_pc     = RPC;
    m_fetch  = 32'd0;
    m_drop   = 32'd0;
  endtask

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    int   sz0;
    bit   ack;
    ent_t e;
    sz0 = mq.size();
    ack = imem_ack_i && m_busy;
    if (redirect_i) begin
      mq.delete();
      m_pc = redirect_pc_i & 32'hFFFF_FFFC;
      if (m_busy && !imem_ack_i) begin
        m_squash = 1'b1;
      end else begin
        if (ack) m_drop = m_drop + 32'd1;
        m_busy   = 1'b0;
        m_squash = 1'b0;
        if (start_i) begin
          m_busy = 1'b1;
          m_addr = m_pc;
        end
      end
    end else begin
      if (sz0 > 0 && inst_ready_i) void'(mq.pop_front());
      if (!m_busy) begin
        if (start_i && sz0 < int'(DEPTH)) begin
          m_busy = 1'b1;
          m_addr = m_pc;
        end
      end else if (ack) begin
        if (m_squash) begin
          m_drop = m_drop + 32'd1;
        end else begin
          e.pc   = m_addr;
          e.inst = imem_data_i;
          mq.push_back(e);
          m_pc    = m_pc + 32'd4;
          m_fetch = m_fetch + 32'd1;
        end
        m_busy   = 1'b0;
        m_squash = 1'b0;
        if (start_i && mq.size() < int'(DEPTH)) begin
          m_busy = 1'b1;
          m_addr = m_pc;
        end
      end
    end
  endtask

  task automatic check_all();
    ent_t h;
    if (mq.size() != 0) h = mq[0];
    else h = '0;
    chk("req",   32'(imem_req_o),   32'(m_busy));
    chk("addr",  imem_addr_o,       m_addr);
    chk("valid", 32'(inst_valid_o), 32'(mq.size() != 0));
    chk("count", 32'(count_o),      32'(mq.size()));
    chk("inst",  inst_o,            h.inst);
    chk("ipc",   inst_pc_o,         h.pc);
`ifdef IFQ_PERF_EN
    chk("fetch_cnt", fetch_cnt_o, m_fetch);
    chk("drop_cnt",  drop_cnt_o,  m_drop);
`endif
  endtask

  // Drive one cycle of inputs at a falling edge, then check at the next one
  task automatic step(input logic s, input logic r, input logic [31:0] rpc,
                      input logic a, input logic [31:0] d, input logic rdy);
    start_i       = s;
    redirect_i    = r;
    redirect_pc_i = rpc;
    imem_ack_i    = a;
    imem_data_i   = d;
    inst_ready_i  = rdy;
    model_step();
    @(negedge clk_i);
    check_all();
  endtask

  initial begin
    rst_i         = 1'b0;
    start_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    imem_ack_i    = 1'b0;
    imem_data_i   = 32'd0;
    inst_ready_i  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    chk("rst_req",   32'(imem_req_o),   32'd0);
    chk("rst_addr",  imem_addr_o,       RPC);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_count", 32'(count_o),      32'd0);
    chk("rst_inst",  inst_o,            32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_all();

    // Streaming fetch: ack every cycle, decode always ready
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    chk("first_req", 32'(imem_req_o), 32'd1);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 32'd0, 1'b1, $urandom(), 1'b1);
      chk("seq_pc",   inst_pc_o,   32'(4 * k));
      chk("seq_addr", imem_addr_o, 32'(4 * (k + 1)));
    end
    step(1'b0, 1'b0, 32'd0, 1'b1, $urandom(), 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);

    // Fill to DEPTH with decode stalled, then one pop reopens fetch at 16
    step(1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'd0, 1'b1, $urandom(), 1'b0);
    chk("full_count", 32'(count_o), 32'd4);
    chk("full_req",   32'(imem_req_o), 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    chk("refill_req",  32'(imem_req_o), 32'd1);
    chk("refill_addr", imem_addr_o, 32'h0000_0010);

    // Redirect while a request is unacked; the late data is dropped
    step(1'b1, 1'b1, 32'h0000_0102, 1'b0, 32'd0, 1'b0);
    chk("drop_count", 32'(count_o), 32'd0);
    chk("drop_hold",  imem_addr_o, 32'h0000_0010);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("drop_valid", 32'(inst_valid_o), 32'd0);
    chk("drop_next",  imem_addr_o, 32'h0000_0100);

    // Redirect, ack and pop in one cycle
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'h1111_0001, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0200, 1'b1, 32'hBAD0_0BAD, 1'b1);
    chk("rda_count", 32'(count_o), 32'd0);
    chk("rda_inst",  inst_o, 32'd0);
    chk("rda_addr",  imem_addr_o, 32'h0000_0200);
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'h2222_0002, 1'b0);
    chk("rda_next_inst", inst_o, 32'h2222_0002);
    chk("rda_next_pc",   inst_pc_o, 32'h0000_0200);

    // PC wrap at the top of the address space
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1, $urandom(), 1'b0);
    chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'h3333_0003, 1'b0);
    chk("wrap_pc0",   inst_pc_o, 32'hFFFF_FFFC);
    chk("wrap_addr2", imem_addr_o, 32'h0000_0000);
    step(1'b1, 1'b0, 32'd0, 1'b1, 32'h4444_0004, 1'b0);
    chk("wrap_count", 32'(count_o), 32'd2);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    chk("wrap_pc1",   inst_pc_o, 32'h0000_0000);
    chk("wrap_inst1", inst_o, 32'h4444_0004);

    // Asynchronous reset while a request is outstanding
    rst_i      = 1'b0;
    start_i    = 1'b0;
    imem_ack_i = 1'b1;
    #1;
    chk("arst_req",   32'(imem_req_o),   32'd0);
    chk("arst_addr",  imem_addr_o,       RPC);
    chk("arst_valid", 32'(inst_valid_o), 32'd0);
    chk("arst_count", 32'(count_o),      32'd0);
    chk("arst_ipc",   inst_pc_o,         32'd0);
`ifdef IFQ_PERF_EN
    chk("arst_fetch", fetch_cnt_o, 32'd0);
    chk("arst_drop",  drop_cnt_o,  32'd0);
`endif
    model_reset();
    @(negedge clk_i);
    check_all();
    rst_i = 1'b1;
    step(1'b0, 1'b0, 32'd0, 1'b1, $urandom(), 1'b1);
    chk("post_rst_req", 32'(imem_req_o), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rpc;
      if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom() & 32'h0000_000F);
      else rpc = $urandom();
      step(1'($urandom_range(99) < 80), 1'($urandom_range(99) < 6), rpc,
           1'($urandom_range(99) < 55), $urandom(), 1'($urandom_range(99) < 60));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
